i2c_transaction_sequencer: RTL and testbench

- Command front-end that sits directly upstream of the I2C byte master.
- Buffers register-read and register-write commands from the host in a small FIFO.
- Launches one master transaction at a time using the master's enable/busy handshake, then captures the master's read data (or write completion) into a single-entry response slot with a valid/ready handshake.
- Decouples bus software from I2C bit timing; the host never polls busy.

---
 rtl/i2c_transaction_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_i2c_transaction_sequencer.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_transaction_sequencer.sv
// I2C transaction sequencer: buffers host register read/write commands in a
// small FIFO, launches them one at a time on the byte master through its
// enable/busy handshake, and returns each result in a single response slot.
// Optional per-transaction timeout is built when I2C_SEQ_TIMEOUT_EN is defined.
module i2c_transaction_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int REGISTER_WIDTH = 8,
    parameter int ADDR_WIDTH     = 7,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_read_write,
    input  logic [ADDR_WIDTH-1:0]        cmd_device_address,
    input  logic [REGISTER_WIDTH-1:0]    cmd_register_address,
    input  logic [DATA_WIDTH-1:0]        cmd_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic                         rsp_read_write,
    output logic [DATA_WIDTH-1:0]        rsp_data,
    output logic                         rsp_error,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         master_enable,
    output logic                         master_read_write,
    output logic [ADDR_WIDTH-1:0]        master_device_address,
    output logic [REGISTER_WIDTH-1:0]    master_register_address,
    output logic [DATA_WIDTH-1:0]        master_mosi_data,
    input  logic [DATA_WIDTH-1:0]        master_miso_data,
    input  logic                         master_busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic                      rw;
        logic [ADDR_WIDTH-1:0]     dev;
        logic [REGISTER_WIDTH-1:0] reg_a;
        logic [DATA_WIDTH-1:0]     data;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_DONE, S_RESPOND} state_t;

    cmd_t                      mem_q [FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]             count_q, count_d;
    logic                      cmd_ready_q;
    state_t                    state_q;
    logic                      master_enable_q, master_rw_q;
    logic [ADDR_WIDTH-1:0]     master_dev_q;
    logic [REGISTER_WIDTH-1:0] master_reg_q;
    logic [DATA_WIDTH-1:0]     master_mosi_q;
    logic                      rsp_valid_q, rsp_rw_q;
    logic [DATA_WIDTH-1:0]     rsp_data_q;
    logic                      push, pop, tmo_hit;
    cmd_t                      cmd_in, head;

    assign cmd_in = '{rw: cmd_read_write, dev: cmd_device_address,
                      reg_a: cmd_register_address, data: cmd_data};
    assign head   = mem_q[rd_ptr_q];
    assign push   = cmd_valid && cmd_ready_q;
    // A stale busy (e.g. left over from before reset or a timeout) holds off the next launch.
    assign pop    = (state_q == S_IDLE) && (count_q != '0) && !rsp_valid_q && !master_busy;

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (!push && pop)
            count_d = count_q - CW'(1);
    end

    // Command FIFO storage, pointers and a registered ready (held low in reset).
    always_ff @(posedge clock) begin
        if (push)
            mem_q[wr_ptr_q] <= cmd_in;
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q     <= count_d;
            cmd_ready_q <= (count_d != CW'(FIFO_DEPTH));
        end
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q;
    logic          rsp_error_q;

    assign tmo_hit   = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign rsp_error = rsp_error_q;

    // Transaction age: restarts on each launch, runs through launch and wait.
    always_ff @(posedge clock) begin
        if (reset || pop)
            tmo_cnt_q <= '0;
        else if ((state_q == S_LAUNCH || state_q == S_WAIT_DONE) && !tmo_hit)
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
    end
`else
    assign tmo_hit   = 1'b0;
    assign rsp_error = 1'b0;
`endif

    // Transaction FSM with registered master request and response slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            master_enable_q <= 1'b0;
            master_rw_q     <= 1'b0;
            master_dev_q    <= '0;
            master_reg_q    <= '0;
            master_mosi_q   <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_rw_q        <= 1'b0;
            rsp_data_q      <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
            rsp_error_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        master_enable_q <= 1'b1;
                        master_rw_q     <= head.rw;
                        master_dev_q    <= head.dev;
                        master_reg_q    <= head.reg_a;
                        master_mosi_q   <= head.data;
                        state_q         <= S_LAUNCH;
                    end
                end
                // Enable stays up until the master's divider tick picks it up.
                S_LAUNCH: begin
                    if (tmo_hit) begin
                        master_enable_q <= 1'b0;
                        rsp_rw_q        <= master_rw_q;
                        rsp_data_q      <= '0;
                        rsp_valid_q     <= 1'b1;
`ifdef I2C_SEQ_TIMEOUT_EN
                        rsp_error_q     <= 1'b1;
`endif
                        state_q         <= S_RESPOND;
                    end else if (master_busy) begin
                        master_enable_q <= 1'b0;
                        state_q         <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!master_busy) begin
                        rsp_rw_q    <= master_rw_q;
                        rsp_data_q  <= master_rw_q ? master_miso_data : '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESPOND;
                    end else if (tmo_hit) begin
                        rsp_rw_q    <= master_rw_q;
                        rsp_data_q  <= '0;
                        rsp_valid_q <= 1'b1;
`ifdef I2C_SEQ_TIMEOUT_EN
                        rsp_error_q <= 1'b1;
`endif
                        state_q     <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
                        rsp_error_q <= 1'b0;
`endif
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready               = cmd_ready_q;
    assign fifo_count              = count_q;
    assign master_enable           = master_enable_q;
    assign master_read_write       = master_rw_q;
    assign master_device_address   = master_dev_q;
    assign master_register_address = master_reg_q;
    assign master_mosi_data        = master_mosi_q;
    assign rsp_valid               = rsp_valid_q;
    assign rsp_read_write          = rsp_rw_q;
    assign rsp_data                = rsp_data_q;

endmodule

// File: tb/tb_i2c_transaction_sequencer.sv
// Bench for i2c_transaction_sequencer: behavioural master model plus a
// command-order reference queue; randomized commands and response back-pressure.
`timescale 1ns/1ps
module tb_i2c_transaction_sequencer;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TMO = 100;
`else
    localparam int TMO = 1000000;
`endif

    typedef struct packed { logic rw; logic [6:0] dev; logic [7:0] ra; logic [7:0] wd; } cmd_t;
    typedef struct packed { logic rw; logic [6:0] dev; logic [7:0] ra; logic [7:0] wd; logic [7:0] miso; } launch_t;

    logic       clock = 1'b0, reset = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_read_write = 1'b0;
    logic [6:0] cmd_device_address = '0;
    logic [7:0] cmd_register_address = '0, cmd_data = '0;
    logic       rsp_valid, rsp_ready = 1'b0, rsp_read_write, rsp_error;
    logic [7:0] rsp_data;
    logic [2:0] fifo_count;
    logic       master_enable, master_read_write;
    logic [6:0] master_device_address;
    logic [7:0] master_register_address, master_mosi_data;
    logic [7:0] master_miso_data;
    logic       master_busy;

    int      n_checks = 0, n_fail = 0;
    cmd_t    exp_q[$];
    launch_t launched_q[$];
    bit      model_on = 1'b1, force_miso = 1'b0, unstable = 1'b0;
    logic [7:0] forced_miso = 8'h00;
    int      hold_cycles = 10;

    i2c_transaction_sequencer #(
        .DATA_WIDTH(8), .REGISTER_WIDTH(8), .ADDR_WIDTH(7), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read_write(cmd_read_write),
        .cmd_device_address(cmd_device_address), .cmd_register_address(cmd_register_address),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_read_write(rsp_read_write),
        .rsp_data(rsp_data), .rsp_error(rsp_error), .fifo_count(fifo_count),
        .master_enable(master_enable), .master_read_write(master_read_write),
        .master_device_address(master_device_address),
        .master_register_address(master_register_address),
        .master_mosi_data(master_mosi_data), .master_miso_data(master_miso_data),
        .master_busy(master_busy)
    );

    always #5 clock = ~clock;

    // Behavioural byte master: busy rises 3 cycles after enable is seen, stays
    // up hold_cycles, then falls with the read byte on miso.
    initial begin : master_model
        int ph, cnt;
        launch_t cur;
        ph = 0; cnt = 0; cur = '0;
        master_busy = 1'b0; master_miso_data = 8'h00;
        forever begin
            @(posedge clock); #2;
            if (reset) begin
                ph = 0; cnt = 0;
                if (model_on) master_busy = 1'b0;
            end else if (model_on) begin
                case (ph)
                    0: if (master_enable) begin
                        cur = '{rw: master_read_write, dev: master_device_address,
                                ra: master_register_address, wd: master_mosi_data, miso: 8'h00};
                        cnt = 0; ph = 1;
                    end
                    1: begin
                        if (!master_enable || {master_read_write, master_device_address,
                            master_register_address, master_mosi_data} != {cur.rw, cur.dev, cur.ra, cur.wd})
                            unstable = 1'b1;
                        cnt++;
                        if (cnt == 3) begin
                            cur.miso = force_miso ? forced_miso : 8'($urandom);
                            launched_q.push_back(cur);
                            master_busy = 1'b1; cnt = 0; ph = 2;
                        end
                    end
                    default: begin
                        cnt++;
                        if (cnt >= hold_cycles) begin
                            master_busy = 1'b0; master_miso_data = cur.miso; ph = 0;
                        end
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.rw = 1'($urandom); c.dev = 7'($urandom); c.ra = 8'($urandom); c.wd = 8'($urandom);
        return c;
    endfunction

    // Offer a command until accepted (bounded); the reference queue records it.
    task automatic push_cmd(input cmd_t c, output bit ok);
        cmd_valid = 1'b1; cmd_read_write = c.rw; cmd_device_address = c.dev;
        cmd_register_address = c.ra; cmd_data = c.wd;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (cmd_ready) ok = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        if (ok) exp_q.push_back(c);
    endtask

    task automatic wait_rsp(output bit got);
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (rsp_valid) begin got = 1'b1; break; end
            tick();
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    // Reference: oldest pushed command, what the master ran, and the data the host must see.
    task automatic ref_next(output cmd_t e, output launch_t l, output logic [7:0] d, output bit have);
        have = (exp_q.size() != 0) && (launched_q.size() != 0);
        e = '0; l = '0; d = 8'h00;
        if (have) begin
            e = exp_q.pop_front(); l = launched_q.pop_front();
            d = e.rw ? l.miso : 8'h00;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({cmd_ready, rsp_valid, rsp_read_write, rsp_data, rsp_error, fifo_count, master_enable,
             master_read_write, master_device_address, master_register_address, master_mosi_data} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: some output nonzero (cmd_ready=%b rsp_valid=%b en=%b cnt=%0d)",
                               cmd_ready, rsp_valid, master_enable, fifo_count);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1 || fifo_count !== 3'd0) begin
            n_fail++; $display("FAIL reset_release: cmd_ready=%b cnt=%0d, want 1 0", cmd_ready, fifo_count);
        end
    endtask

    task automatic test_single_write();
        cmd_t e; launch_t l; logic [7:0] d; bit have, got; int hi;
        cmd_t c;
        c = '{rw: 1'b0, dev: 7'h50, ra: 8'h10, wd: 8'hA5};
        hold_cycles = 40;
        cmd_valid = 1'b1; cmd_read_write = c.rw; cmd_device_address = c.dev;
        cmd_register_address = c.ra; cmd_data = c.wd;
        n_checks++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready: cmd_ready=%b want 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0; exp_q.push_back(c);
        n_checks++;
        if (master_enable !== 1'b0) begin n_fail++; $display("FAIL wr_en_n1: enable=%b want 0", master_enable); end
        tick();
        n_checks++;
        if (master_enable !== 1'b1 || {master_read_write, master_device_address, master_register_address,
            master_mosi_data} !== c) begin
            n_fail++; $display("FAIL wr_en_n2: enable=%b fields=%h want 1 %h", master_enable,
                {master_read_write, master_device_address, master_register_address, master_mosi_data}, c);
        end
        hi = 0;
        while (master_enable === 1'b1 && hi < 200) begin hi++; tick(); end
        n_checks++;
        if (hi != 4) begin n_fail++; $display("FAIL wr_enable_len: enable high %0d cycles want 4", hi); end
        wait_rsp(got);
        ref_next(e, l, d, have);
        n_checks++;
        if (!got || !have || rsp_read_write !== 1'b0 || rsp_data !== 8'h00 || {l.rw, l.dev, l.ra, l.wd} !== e) begin
            n_fail++; $display("FAIL wr_rsp: got=%b rw=%b data=%h ran=%h want rw=0 data=00 cmd=%h",
                               got, rsp_read_write, rsp_data, {l.rw, l.dev, l.ra, l.wd}, e);
        end
        consume();
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_consume: rsp_valid=%b want 0", rsp_valid); end
    endtask

    task automatic test_single_read();
        cmd_t e; launch_t l; logic [7:0] d; bit have, got, ok, held;
        hold_cycles = $urandom_range(5, 20);
        force_miso = 1'b1; forced_miso = 8'h3C;
        push_cmd('{rw: 1'b1, dev: 7'h68, ra: 8'h75, wd: 8'($urandom)}, ok);
        wait_rsp(got);
        held = 1'b1;
        repeat ($urandom_range(3, 8)) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h3C || rsp_read_write !== 1'b1) held = 1'b0;
        end
        ref_next(e, l, d, have);
        n_checks++;
        if (!ok || !got || !have || rsp_data !== 8'h3C || rsp_read_write !== 1'b1 || d !== 8'h3C) begin
            n_fail++; $display("FAIL rd_rsp: ok=%b got=%b rw=%b data=%h want rw=1 data=3c", ok, got, rsp_read_write, rsp_data);
        end
        n_checks++;
        if (!held) begin n_fail++; $display("FAIL rd_hold: response not held stable while rsp_ready=0 (held=%b want 1)", held); end
        consume();
        force_miso = 1'b0;
    endtask

    task automatic test_fifo_full();
        cmd_t e; launch_t l; logic [7:0] d; bit have, got, ok, all_ok, stalled;
        cmd_t c6;
        hold_cycles = $urandom_range(3, 10);
        all_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin push_cmd(rand_cmd(), ok); all_ok &= ok; end
        wait_rsp(got);
        n_checks++;
        if (!all_ok || !got || fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_level: pushed=%b got=%b cnt=%0d ready=%b want 1 1 4 0",
                               all_ok, got, fifo_count, cmd_ready);
        end
        c6 = rand_cmd();
        cmd_valid = 1'b1; cmd_read_write = c6.rw; cmd_device_address = c6.dev;
        cmd_register_address = c6.ra; cmd_data = c6.wd;
        stalled = 1'b1;
        repeat (5) begin tick(); if (fifo_count !== 3'd4 || cmd_ready !== 1'b0) stalled = 1'b0; end
        n_checks++;
        if (!stalled) begin n_fail++; $display("FAIL full_stall: 6th command got in (cnt=%0d) want held at 4", fifo_count); end
        for (int k = 0; k < 6; k++) begin
            if (k > 0) wait_rsp(got);
            ref_next(e, l, d, have);
            n_checks++;
            if (!got || !have || rsp_read_write !== e.rw || rsp_data !== d || {l.rw, l.dev, l.ra, l.wd} !== e) begin
                n_fail++; $display("FAIL full_order[%0d]: rw=%b data=%h ran=%h want rw=%b data=%h cmd=%h",
                                   k, rsp_read_write, rsp_data, {l.rw, l.dev, l.ra, l.wd}, e.rw, d, e);
            end
            consume();
            if (k == 0) begin push_cmd(c6, ok); all_ok &= ok; end
        end
        n_checks++;
        if (!all_ok || exp_q.size() != 0) begin
            n_fail++; $display("FAIL full_drain: pushed=%b leftover=%0d want 1 0", all_ok, exp_q.size());
        end
    endtask

    task automatic test_simul_push_pop();
        cmd_t e; launch_t l; logic [7:0] d; bit have, got, ok, all_ok;
        cmd_t cd;
        hold_cycles = $urandom_range(2, 8);
        all_ok = 1'b1;
        push_cmd(rand_cmd(), ok); all_ok &= ok;
        wait_rsp(got);
        ref_next(e, l, d, have);
        n_checks++;
        if (!got || !have || rsp_read_write !== e.rw || rsp_data !== d) begin
            n_fail++; $display("FAIL sim_first: rw=%b data=%h want rw=%b data=%h", rsp_read_write, rsp_data, e.rw, d);
        end
        push_cmd(rand_cmd(), ok); all_ok &= ok;
        push_cmd(rand_cmd(), ok); all_ok &= ok;
        consume();
        cd = rand_cmd();
        cmd_valid = 1'b1; cmd_read_write = cd.rw; cmd_device_address = cd.dev;
        cmd_register_address = cd.ra; cmd_data = cd.wd;
        n_checks++;
        if (fifo_count !== 3'd2 || cmd_ready !== 1'b1 || master_enable !== 1'b0) begin
            n_fail++; $display("FAIL sim_before: cnt=%0d ready=%b en=%b want 2 1 0", fifo_count, cmd_ready, master_enable);
        end
        tick();
        cmd_valid = 1'b0; exp_q.push_back(cd);
        n_checks++;
        if (fifo_count !== 3'd2 || master_enable !== 1'b1) begin
            n_fail++; $display("FAIL sim_after: cnt=%0d en=%b want 2 1", fifo_count, master_enable);
        end
        for (int k = 0; k < 3; k++) begin
            wait_rsp(got);
            ref_next(e, l, d, have);
            n_checks++;
            if (!got || !have || rsp_read_write !== e.rw || rsp_data !== d || {l.rw, l.dev, l.ra, l.wd} !== e) begin
                n_fail++; $display("FAIL sim_order[%0d]: rw=%b data=%h ran=%h want rw=%b data=%h cmd=%h",
                                   k, rsp_read_write, rsp_data, {l.rw, l.dev, l.ra, l.wd}, e.rw, d, e);
            end
            consume();
        end
        n_checks++;
        if (!all_ok || exp_q.size() != 0 || fifo_count !== 3'd0) begin
            n_fail++; $display("FAIL sim_drain: pushed=%b leftover=%0d cnt=%0d want 1 0 0", all_ok, exp_q.size(), fifo_count);
        end
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        hold_cycles = 30;
        for (int i = 0; i < 4; i++) push_cmd(rand_cmd(), ok);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin if (master_busy) seen = 1'b1; else tick(); end
        tick(); tick();
        n_checks++;
        if (!seen || fifo_count !== 3'd3 || master_enable !== 1'b0) begin
            n_fail++; $display("FAIL mid_setup: busy_seen=%b cnt=%0d en=%b want 1 3 0", seen, fifo_count, master_enable);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({cmd_ready, rsp_valid, rsp_read_write, rsp_data, rsp_error, fifo_count, master_enable,
             master_read_write, master_device_address, master_register_address, master_mosi_data} !== '0) begin
            n_fail++; $display("FAIL mid_reset: en=%b cnt=%0d rsp_valid=%b ready=%b want all 0",
                               master_enable, fifo_count, rsp_valid, cmd_ready);
        end
        reset = 1'b0;
        exp_q.delete(); launched_q.delete();
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1 || fifo_count !== 3'd0) begin
            n_fail++; $display("FAIL mid_release: ready=%b cnt=%0d want 1 0", cmd_ready, fifo_count);
        end
        repeat (10) tick();
        n_checks++;
        if (rsp_valid !== 1'b0 || master_enable !== 1'b0) begin
            n_fail++; $display("FAIL mid_discard: rsp_valid=%b en=%b want 0 0", rsp_valid, master_enable);
        end
    endtask

    task automatic test_stale_busy();
        cmd_t e; launch_t l; logic [7:0] d; bit have, got, ok, quiet;
        model_on = 1'b0; master_busy = 1'b1; hold_cycles = 5;
        push_cmd(rand_cmd(), ok);
        quiet = 1'b1;
        repeat (8) begin tick(); if (master_enable !== 1'b0) quiet = 1'b0; end
        n_checks++;
        if (!ok || !quiet) begin n_fail++; $display("FAIL stale_hold: pushed=%b quiet=%b want 1 1", ok, quiet); end
        master_busy = 1'b0; model_on = 1'b1;
        wait_rsp(got);
        ref_next(e, l, d, have);
        n_checks++;
        if (!got || !have || rsp_read_write !== e.rw || rsp_data !== d || {l.rw, l.dev, l.ra, l.wd} !== e) begin
            n_fail++; $display("FAIL stale_rsp: rw=%b data=%h want rw=%b data=%h", rsp_read_write, rsp_data, e.rw, d);
        end
        consume();
    endtask

    task automatic test_random();
        int n_ok;
        n_ok = 0;
        fork
            begin : pusher
                bit ok;
                for (int i = 0; i < 24; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    push_cmd(rand_cmd(), ok);
                end
            end
            begin : drainer
                cmd_t e; launch_t l; logic [7:0] d; bit have, got;
                for (int k = 0; k < 24; k++) begin
                    hold_cycles = $urandom_range(1, 12);
                    wait_rsp(got);
                    repeat ($urandom_range(0, 4)) tick();
                    ref_next(e, l, d, have);
                    n_checks++;
                    if (!got || !have || rsp_read_write !== e.rw || rsp_data !== d || rsp_error !== 1'b0 ||
                        {l.rw, l.dev, l.ra, l.wd} !== e) begin
                        n_fail++; $display("FAIL rand[%0d]: got=%b rw=%b data=%h ran=%h want rw=%b data=%h cmd=%h",
                                           k, got, rsp_read_write, rsp_data, {l.rw, l.dev, l.ra, l.wd}, e.rw, d, e);
                    end else n_ok++;
                    consume();
                end
            end
        join
        n_checks++;
        if (n_ok != 24 || unstable || exp_q.size() != 0 || launched_q.size() != 0) begin
            n_fail++; $display("FAIL rand_summary: ok=%0d unstable=%b left=%0d/%0d want 24 0 0/0",
                               n_ok, unstable, exp_q.size(), launched_q.size());
        end
    endtask

`ifdef I2C_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        bit ok, seen; int hi;
        model_on = 1'b0; master_busy = 1'b0;
        push_cmd(rand_cmd(), ok);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin if (master_enable) seen = 1'b1; else tick(); end
        hi = 0;
        while (master_enable === 1'b1 && hi < 300) begin hi++; tick(); end
        n_checks++;
        if (!seen || hi != 100 || rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_data !== 8'h00) begin
            n_fail++; $display("FAIL timeout: en_cycles=%0d valid=%b err=%b data=%h want 100 1 1 00",
                               hi, rsp_valid, rsp_error, rsp_data);
        end
        consume();
        n_checks++;
        if (rsp_error !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL timeout_clear: err=%b valid=%b want 0 0", rsp_error, rsp_valid);
        end
        exp_q.delete(); launched_q.delete();
        model_on = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_fifo_full();
        test_simul_push_pop();
        test_reset_mid();
        test_stale_busy();
        test_random();
`ifdef I2C_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
